// File: rtl/rst_sequencer_pkg.sv
// Bus constants, register offsets and FSM encoding shared by the reset sequencer files.
package rst_sequencer_pkg;

   localparam int BUS_WIDTH     = 32;
   localparam int BUS_ACC_WIDTH = 2;
   localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_1B = 2'd0;

   localparam int RST_SEQ_CTRL = 0;
   localparam int RST_SEQ_DLY  = 1;
   localparam int RST_SEQ_STAT = 2;

   localparam logic [7:0] RST_SEQ_ALL = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_STEP   = 2'd2,
      ST_SINGLE = 2'd3
   } rst_seq_state_e;

   // A programmed gap of 0 still has to last one cycle.
   function automatic logic [7:0] eff_dly(input logic [7:0] v);
      return (v == 8'd0) ? 8'd1 : v;
   endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// 8-bit loadable down-counter; expire is high for the one cycle the count sits at 1.
// Always enabled; load has priority over counting.
module rst_seq_timer (
   input  logic       clk,
   input  logic       load,
   input  logic [7:0] d,
   output logic       expire
);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = d;
      end else if (cnt_q != 8'd0) begin
         cnt_d = cnt_q - 8'd1;
      end
   end

   // No reset of its own: the sequencer holds load high throughout rst.
   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

   assign expire = (cnt_q == 8'd1);

endmodule

// File: rtl/rst_sequencer.sv
// Ordered release of a per-module active-low reset vector with a programmable gap, plus single pulses.
// Bus slave: resp/rdata registered one cycle after a legal req; fault is combinational, no stalls.
module rst_sequencer
   import rst_sequencer_pkg::*;
#(
   parameter int N        = 4,
   parameter int VA_WIDTH = 2,
   parameter int DLY_RST  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic [N-1:0]             rst_ob,
   input  logic [VA_WIDTH-1:0]      addr,
   input  logic                     w_rb,
   input  logic [BUS_ACC_WIDTH-1:0] acc,
   output logic [BUS_WIDTH-1:0]     rdata,
   input  logic [BUS_WIDTH-1:0]     wdata,
   input  logic                     req,
   output logic                     resp,
   output logic                     fault
);

   localparam logic [VA_WIDTH-1:0] A_CTRL = VA_WIDTH'(RST_SEQ_CTRL);
   localparam logic [VA_WIDTH-1:0] A_DLY  = VA_WIDTH'(RST_SEQ_DLY);
   localparam logic [VA_WIDTH-1:0] A_STAT = VA_WIDTH'(RST_SEQ_STAT);
   localparam logic [7:0]          N_B    = 8'(N);
   localparam logic [3:0]          LAST   = 4'(N - 1);
   localparam logic [7:0]          D_RST  = eff_dly(8'(DLY_RST));

   rst_seq_state_e       state_q;
   logic [3:0]           step_q;
   logic [N-1:0]         rst_ob_q;
   logic [7:0]           dly_q;
   logic [7:0]           dly_d;
   logic                 resp_q;
   logic [BUS_WIDTH-1:0] rdata_q;
   logic [BUS_WIDTH-1:0] rdata_d;

   logic       busy;
   logic [7:0] wbyte;
   logic       illegal;
   logic       legal;
   logic       ctrl_wr;
   logic       go_all;
   logic       go_one;
   logic       dly_wr;
   logic [3:0] next_idx;
   logic       tmr_load;
   logic [7:0] tmr_d;
   logic       tmr_expire;

   function automatic logic [N-1:0] pulse_mask(input logic [3:0] idx);
      logic [N-1:0] m;
      for (int b = 0; b < N; b++) begin
         m[b] = (4'(b) != idx);
      end
      return m;
   endfunction

   function automatic logic [N-1:0] released_upto(input logic [3:0] idx);
      logic [N-1:0] m;
      for (int b = 0; b < N; b++) begin
         m[b] = (4'(b) <= idx);
      end
      return m;
   endfunction

   assign busy  = (state_q != ST_IDLE);
   assign wbyte = wdata[7:0];

   always_comb begin
      illegal = 1'b0;
      if (addr > A_STAT) begin
         illegal = 1'b1;
      end
      if (acc != BUS_ACC_1B) begin
         illegal = 1'b1;
      end
      if (w_rb && (addr == A_STAT)) begin
         illegal = 1'b1;
      end
      if (!w_rb && (addr == A_CTRL)) begin
         illegal = 1'b1;
      end
      if (w_rb && (addr == A_CTRL) && (busy || ((wbyte != RST_SEQ_ALL) && (wbyte >= N_B)))) begin
         illegal = 1'b1;
      end
      if (w_rb && (wdata[BUS_WIDTH-1:8] != '0)) begin
         illegal = 1'b1;
      end
   end

   assign fault   = req & illegal;
   assign legal   = req & ~illegal & ~rst;
   assign ctrl_wr = legal & w_rb & (addr == A_CTRL);
   assign go_all  = ctrl_wr & (wbyte == RST_SEQ_ALL);
   assign go_one  = ctrl_wr & (wbyte != RST_SEQ_ALL);
   assign dly_wr  = legal & w_rb & (addr == A_DLY);

   assign dly_d = dly_wr ? wbyte : dly_q;

   always_comb begin
      rdata_d = '0;
      if (legal && !w_rb) begin
         if (addr == A_DLY) begin
            rdata_d[7:0] = dly_q;
         end else if (addr == A_STAT) begin
            rdata_d[7:0] = {step_q, 3'b000, busy};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dly_q   <= 8'(DLY_RST);
         resp_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         dly_q   <= dly_d;
         resp_q  <= legal;
         rdata_q <= rdata_d;
      end
   end

   // Index released by the next expiry: 0 leaving HOLD, k+1 while stepping.
   assign next_idx = (state_q == ST_HOLD) ? 4'd0 : (step_q + 4'd1);

   // Phase length comes from dly_q before any write landing on this edge.
   always_comb begin
      tmr_load = 1'b0;
      tmr_d    = eff_dly(dly_q);
      if (rst) begin
         tmr_load = 1'b1;
         tmr_d    = D_RST;
      end else if (go_all || go_one) begin
         tmr_load = 1'b1;
      end else if (tmr_expire && ((state_q == ST_HOLD) || (state_q == ST_STEP))
                   && (next_idx != LAST)) begin
         tmr_load = 1'b1;
      end
   end

   rst_seq_timer u_timer (
      .clk    (clk),
      .load   (tmr_load),
      .d      (tmr_d),
      .expire (tmr_expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_HOLD;
         step_q   <= 4'd0;
         rst_ob_q <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (go_all) begin
                  state_q  <= ST_HOLD;
                  step_q   <= 4'd0;
                  rst_ob_q <= '0;
               end else if (go_one) begin
                  state_q  <= ST_SINGLE;
                  rst_ob_q <= pulse_mask(wbyte[3:0]);
               end
            end
            ST_HOLD, ST_STEP: begin
               if (tmr_expire) begin
                  rst_ob_q <= released_upto(next_idx);
                  if (next_idx == LAST) begin
                     state_q <= ST_IDLE;
                     step_q  <= 4'd0;
                  end else begin
                     state_q <= ST_STEP;
                     step_q  <= next_idx;
                  end
               end
            end
            ST_SINGLE: begin
               if (tmr_expire) begin
                  state_q  <= ST_IDLE;
                  rst_ob_q <= '1;
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               rst_ob_q <= '1;
            end
         endcase
      end
   end

   assign rst_ob = rst_ob_q;
   assign resp   = resp_q;
   assign rdata  = rdata_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Randomised and directed bench for rst_sequencer against a time-indexed release-schedule model.
module tb_rst_sequencer;
   import rst_sequencer_pkg::*;

   localparam int N       = 4;
   localparam int VA      = 2;
   localparam int DLY_RST = 8;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic [N-1:0]             rst_ob;
   logic [VA-1:0]            addr = '0;
   logic                     w_rb = 1'b0;
   logic [BUS_ACC_WIDTH-1:0] acc = '0;
   logic [BUS_WIDTH-1:0]     rdata;
   logic [BUS_WIDTH-1:0]     wdata = '0;
   logic                     req = 1'b0;
   logic                     resp;
   logic                     fault;

   always #5 clk = ~clk;

   rst_sequencer #(.N(N), .VA_WIDTH(VA), .DLY_RST(DLY_RST)) dut (
      .clk(clk), .rst(rst), .rst_ob(rst_ob), .addr(addr), .w_rb(w_rb), .acc(acc),
      .rdata(rdata), .wdata(wdata), .req(req), .resp(resp), .fault(fault)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Model: mode 0 idle, 1 full sequence (rel[k] = edge where bit k rises), 2 single pulse.
   int mode = 0;
   int t0 = 0;
   int seq_d0 = 1;
   int rel[N];
   int sa = 0, sd = 1, si = 0;
   int hist_t[$];
   int hist_v[$];
   bit pend_resp = 1'b0;
   logic [31:0] pend_rdata = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic int eff(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   function automatic int dly_before(input int t);
      int v = DLY_RST;
      foreach (hist_t[j]) if (hist_t[j] < t) v = hist_v[j];
      return v;
   endfunction

   task automatic plan_seq();
      int p = t0;
      for (int k = 0; k < N; k++) begin
         rel[k] = p + ((k == 0) ? seq_d0 : eff(dly_before(p)));
         p = rel[k];
      end
   endtask

   function automatic logic [N-1:0] exp_ob(input int t);
      logic [N-1:0] v = '1;
      for (int k = 0; k < N; k++) begin
         if (mode == 1) v[k] = (t >= rel[k]);
         if (mode == 2 && k == si) v[k] = !(t >= sa && t < sa + sd);
      end
      return v;
   endfunction

   function automatic bit busy_at(input int t);
      if (mode == 1) return t < rel[N-1];
      if (mode == 2) return t < sa + sd;
      return 1'b0;
   endfunction

   function automatic int step_at(input int t);
      int k = 0;
      if (mode != 1 || !busy_at(t)) return 0;
      for (int j = 0; j < N; j++) if (t >= rel[j]) k = j;
      return k;
   endfunction

   task automatic tick();
      @(posedge clk);
      cyc++;
      if (rst) begin
         mode = 1;
         t0 = cyc;
         seq_d0 = eff(DLY_RST);
         hist_t.delete();
         hist_v.delete();
         hist_t.push_back(cyc);
         hist_v.push_back(DLY_RST);
         plan_seq();
      end
      #1;
      check("rst_ob", 32'(rst_ob), 32'(exp_ob(cyc)));
      check("resp", 32'(resp), 32'(pend_resp));
      check("rdata", rdata, pend_resp ? pend_rdata : 32'd0);
      pend_resp = 1'b0;
   endtask

   task automatic do_acc(input bit w, input int a, input int ac, input logic [31:0] wd);
      bit ok;
      logic [31:0] rd;
      logic [7:0] b;
      int acpt;
      acpt = cyc + 1;
      b = wd[7:0];
      ok = (a <= 2) && (ac == 0) && (!w || wd[31:8] == 24'd0);
      if (w && a == 2) ok = 1'b0;
      if (!w && a == 0) ok = 1'b0;
      if (w && a == 0 && (busy_at(cyc) || (b != 8'hFF && int'(b) >= N))) ok = 1'b0;
      rd = '0;
      if (ok && !w) begin
         if (a == 1) rd = 32'(dly_before(acpt));
         else rd = {24'd0, 4'(step_at(cyc)), 3'd0, busy_at(cyc)};
      end
      addr = a[VA-1:0];
      w_rb = w;
      acc = ac[BUS_ACC_WIDTH-1:0];
      wdata = wd;
      req = 1'b1;
      #1;
      check("fault", 32'(fault), 32'(!ok));
      if (ok && w && a == 0) begin
         if (b == 8'hFF) begin
            mode = 1; t0 = acpt; seq_d0 = eff(dly_before(acpt)); plan_seq();
         end else begin
            mode = 2; sa = acpt; sd = eff(dly_before(acpt)); si = int'(b);
         end
      end
      if (ok && w && a == 1) begin
         hist_t.push_back(acpt);
         hist_v.push_back(int'(b));
         if (mode == 1) plan_seq();
      end
      pend_resp = ok;
      pend_rdata = rd;
      tick();
      req = 1'b0;
      wdata = '0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 3000 && busy_at(cyc); i++) tick();
   endtask

   // Returns the edge at which the DUT vector first reads all ones, or -1.
   task automatic measure_done(output int done);
      done = -1;
      for (int i = 0; i < 3000 && done < 0; i++) begin
         tick();
         if (rst_ob == '1) done = cyc;
      end
   endtask

   initial begin
      int done;
      int acpt;
      int r_edge;
      int cnt;

      // Power-up reset for three cycles, then the automatic sequence.
      rst = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      r_edge = cyc;
      rst = 1'b0;
      do_acc(1'b0, 2, 0, 32'd0);
      measure_done(done);
      check("por_release_edge", 32'(done), 32'(r_edge + N * DLY_RST));
      tick();

      // DLY=3 round trip, full sequence, CTRL while busy, STAT while stepping.
      do_acc(1'b1, 1, 0, 32'd3);
      do_acc(1'b0, 1, 0, 32'd0);
      acpt = cyc + 1;
      do_acc(1'b1, 0, 0, 32'hFF);
      do_acc(1'b1, 0, 0, 32'h1);
      for (int i = 0; i < 4; i++) tick();
      do_acc(1'b0, 2, 0, 32'd0);
      measure_done(done);
      check("seq_d3_done", 32'(done), 32'(acpt + N * 3));

      // Single pulse on module 2 with DLY=5.
      do_acc(1'b1, 1, 0, 32'd5);
      do_acc(1'b1, 0, 0, 32'd2);
      cnt = 0;
      for (int i = 0; i < 50 && busy_at(cyc); i++) begin
         if (rst_ob == 4'b1011) cnt++;
         tick();
      end
      check("single_width", 32'(cnt), 32'd5);

      // Illegal accesses: no response, no state change.
      do_acc(1'b0, 3, 0, 32'd0);
      do_acc(1'b1, 1, 1, 32'd9);
      do_acc(1'b1, 0, 0, 32'd7);
      do_acc(1'b1, 1, 0, 32'h100);
      do_acc(1'b1, 2, 0, 32'd1);
      do_acc(1'b0, 0, 0, 32'd0);
      do_acc(1'b0, 1, 0, 32'd0);

      // DLY=0 behaves as a one-cycle gap.
      do_acc(1'b1, 1, 0, 32'd0);
      acpt = cyc + 1;
      do_acc(1'b1, 0, 0, 32'hFF);
      measure_done(done);
      check("seq_d0_done", 32'(done), 32'(acpt + N));

      // DLY write landing on a phase-start edge only affects later phases.
      do_acc(1'b1, 1, 0, 32'd2);
      acpt = cyc + 1;
      do_acc(1'b1, 0, 0, 32'hFF);
      tick();
      do_acc(1'b1, 1, 0, 32'd6);
      measure_done(done);
      check("dly_change_done", 32'(done), 32'(acpt + 2 + 2 + 6 + 6));

      // rst mid-STEP at k=2, with a request in the reset cycle that must be ignored.
      do_acc(1'b1, 1, 0, 32'd4);
      do_acc(1'b1, 0, 0, 32'hFF);
      for (int i = 0; i < 200 && !(busy_at(cyc) && step_at(cyc) == 2); i++) tick();
      rst = 1'b1;
      addr = 2'd1; w_rb = 1'b1; acc = '0; wdata = 32'h55; req = 1'b1;
      tick();
      check("rst_all_low", 32'(rst_ob), 32'd0);
      rst = 1'b0; req = 1'b0; wdata = '0;
      do_acc(1'b0, 1, 0, 32'd0);
      r_edge = cyc - 1;
      measure_done(done);
      check("rst_restart_done", 32'(done), 32'(r_edge + N * DLY_RST));

      // Random traffic.
      for (int it = 0; it < 80; it++) begin
         bit w;
         int a, ac;
         logic [31:0] wd;
         w = 1'($urandom_range(0, 1));
         a = ($urandom_range(0, 9) < 9) ? int'($urandom_range(0, 2)) : 3;
         ac = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
         wd = '0;
         if (w) begin
            if (a == 0) wd = ($urandom_range(0, 9) < 4) ? 32'hFF : 32'($urandom_range(0, N + 3));
            else if (a == 1) wd = 32'($urandom_range(0, 5));
            else wd = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) wd = wd | (32'h100 << $urandom_range(0, 23));
         end
         do_acc(w, a, ac, wd);
         for (int g = $urandom_range(0, 6); g > 0; g--) tick();
         if ($urandom_range(0, 9) < 3) wait_idle();
      end
      wait_idle();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
